fp_add_align: RTL

Two-stage pipelined alignment front end for the single-precision floating-point add/sub unit in the out-of-order core.
- Unpacks two IEEE-754 binary32 operands, orders them by magnitude and right-shifts the smaller 24-bit significand by the exponent difference.
- Presents the 24-bit significands, effective operation and guard/round/sticky bits directly to the 24-bit adder/subtractor stage, which consumes them unregistered.
- Carries a ROB tag and honours pipeline flush.

---
 rtl/fp_add_align.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_add_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_add_align: two-stage binary32 add/sub alignment front end (unpack,    |
// | magnitude order, shift the smaller significand, G/R/S, specials).        |
// | Option macro: FP_ALIGN_DENORM_EN (keep denormals; else flush-to-zero).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_add_align #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      mant_big,
  output logic [23:0]      mant_small,
  output logic             add_sub,
  output logic [7:0]       exp_out,
  output logic             sign_out,
  output logic             guard,
  output logic             round,
  output logic             sticky,
  output logic             nan_out,
  output logic             inf_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [7:0] c_max_shift = 8'd27;

  logic [7:0]  w_ea, w_eb, w_eeff_a, w_eeff_b, w_exp_big, w_exp_small, w_diff;
  logic [23:0] w_mant_a, w_mant_b;
  logic        w_sb_eff, w_swap, w_eff_sub;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_nan, w_inf;
  logic [4:0]  w_d;
  logic        w_s2_load, w_s1_adv, w_in_fire;
  logic [50:0] w_ext;

  logic             r_s1_valid, r_s1_sub, r_s1_sign, r_s1_nan, r_s1_inf;
  logic [23:0]      r_s1_big, r_s1_small;
  logic [7:0]       r_s1_exp;
  logic [4:0]       r_s1_d;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid, r_s2_sub, r_s2_sign, r_s2_nan, r_s2_inf;
  logic             r_s2_g, r_s2_r, r_s2_s;
  logic [23:0]      r_s2_big, r_s2_small;
  logic [7:0]       r_s2_exp;
  logic [TAG_W-1:0] r_s2_tag;

  assign w_ea = op_a[30:23];
  assign w_eb = op_b[30:23];
`ifdef FP_ALIGN_DENORM_EN
  assign w_mant_a = {(w_ea != 8'd0), op_a[22:0]};
  assign w_mant_b = {(w_eb != 8'd0), op_b[22:0]};
`else
  // Flush-to-zero: a zero-exponent operand contributes no significand bits.
  assign w_mant_a = (w_ea != 8'd0) ? {1'b1, op_a[22:0]} : 24'd0;
  assign w_mant_b = (w_eb != 8'd0) ? {1'b1, op_b[22:0]} : 24'd0;
`endif
  assign w_eeff_a = (w_ea == 8'd0) ? 8'd1 : w_ea;
  assign w_eeff_b = (w_eb == 8'd0) ? 8'd1 : w_eb;

  assign w_sb_eff  = op_b[31] ^ op_sub;
  assign w_eff_sub = op_a[31] ^ w_sb_eff;
  // Strict compare keeps A on top for exact ties.
  assign w_swap      = {w_eeff_b, w_mant_b} > {w_eeff_a, w_mant_a};
  assign w_exp_big   = w_swap ? w_eeff_b : w_eeff_a;
  assign w_exp_small = w_swap ? w_eeff_a : w_eeff_b;
  assign w_diff      = w_exp_big - w_exp_small;
  assign w_d         = (w_diff > c_max_shift) ? c_max_shift[4:0] : w_diff[4:0];

  assign w_nan_a = (w_ea == 8'hFF) && (op_a[22:0] != 23'd0);
  assign w_nan_b = (w_eb == 8'hFF) && (op_b[22:0] != 23'd0);
  assign w_inf_a = (w_ea == 8'hFF) && (op_a[22:0] == 23'd0);
  assign w_inf_b = (w_eb == 8'hFF) && (op_b[22:0] == 23'd0);
  assign w_nan   = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_eff_sub);
  assign w_inf   = (w_inf_a || w_inf_b) && !w_nan;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  // 27 guard positions below the significand: G at 26, R at 25, sticky 24..0.
  assign w_ext = {r_s1_small, 27'd0} >> r_s1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_big   <= 24'd0;
      r_s1_small <= 24'd0;
      r_s1_exp   <= 8'd0;
      r_s1_d     <= 5'd0;
      r_s1_tag   <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire && !flush) begin
        r_s1_sub   <= w_eff_sub;
        r_s1_sign  <= w_swap ? w_sb_eff : op_a[31];
        r_s1_nan   <= w_nan;
        r_s1_inf   <= w_inf;
        r_s1_big   <= w_swap ? w_mant_b : w_mant_a;
        r_s1_small <= w_swap ? w_mant_a : w_mant_b;
        r_s1_exp   <= w_exp_big;
        r_s1_d     <= w_d;
        r_s1_tag   <= tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sub   <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_nan   <= 1'b0;
      r_s2_inf   <= 1'b0;
      r_s2_g     <= 1'b0;
      r_s2_r     <= 1'b0;
      r_s2_s     <= 1'b0;
      r_s2_big   <= 24'd0;
      r_s2_small <= 24'd0;
      r_s2_exp   <= 8'd0;
      r_s2_tag   <= '0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv && !flush) begin
        r_s2_sub   <= r_s1_sub;
        r_s2_sign  <= r_s1_sign;
        r_s2_nan   <= r_s1_nan;
        r_s2_inf   <= r_s1_inf;
        r_s2_g     <= w_ext[26];
        r_s2_r     <= w_ext[25];
        r_s2_s     <= |w_ext[24:0];
        r_s2_big   <= r_s1_big;
        r_s2_small <= w_ext[50:27];
        r_s2_exp   <= r_s1_exp;
        r_s2_tag   <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign mant_big   = r_s2_big;
  assign mant_small = r_s2_small;
  assign add_sub    = r_s2_sub;
  assign exp_out    = r_s2_exp;
  assign sign_out   = r_s2_sign;
  assign guard      = r_s2_g;
  assign round      = r_s2_r;
  assign sticky     = r_s2_s;
  assign nan_out    = r_s2_nan;
  assign inf_out    = r_s2_inf;
  assign tag_out    = r_s2_tag;

endmodule
`default_nettype wire
